mat_transform_2pass: RTL and testbench

- Parametrised NxN two-pass separable matrix transform engine. Computes Y = (X * C0) * C1: pass 1 produces T = X*C0 into an internal buffer, pass 2 produces Y = T*C1.
- Successor to the fixed 8x8 iCDT datapath. Adds generic size and widths, signed rounding and saturation, a start/busy/done handshake, abort, and a saturation flag.
- Sits between the input-frame memory and coefficient ROM banks on one side and the output-frame memory on the other.

---
 rtl/mat_transform_2pass_if.sv | 39 +++
 rtl/mat_transform_2pass.sv | 208 ++++++++++++++++++++
 tb/tb_mat_transform_2pass.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_transform_2pass_if.sv
// Frame handshake, memory-port and Y-write bundle for mat_transform_2pass.
// slave is the engine side; master is the frame/memory side.
interface mat_transform_2pass_if #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
);
  localparam int LN = $clog2(N);

  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                sat_flag;
  logic [LN-1:0]       x_row_addr;
  logic [N*DATA_W-1:0] x_row_data;
  logic                coef_bank;
  logic [LN-1:0]       coef_col_addr;
  logic [N*COEF_W-1:0] coef_col_data;
  logic                y_wr_en;
  logic [LN-1:0]       y_wr_i;
  logic [LN-1:0]       y_wr_j;
  logic [OUT_W-1:0]    y_wr_data;

  modport slave (
    input  start, abort, x_row_data, coef_col_data,
    output busy, done, sat_flag, x_row_addr,
    output coef_bank, coef_col_addr,
    output y_wr_en, y_wr_i, y_wr_j, y_wr_data
  );

  modport master (
    output start, abort, x_row_data, coef_col_data,
    input  busy, done, sat_flag, x_row_addr,
    input  coef_bank, coef_col_addr,
    input  y_wr_en, y_wr_i, y_wr_j, y_wr_data
  );
endinterface

// File: rtl/mat_transform_2pass.sv
// Two-pass separable NxN transform Y = (X*C0)*C1.
// Pass 1 fills the internal T buffer; pass 2 streams Y row-major.
module mat_transform_2pass #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TMP_W  = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT1 = 0,
  parameter int SHIFT2 = 0
) (
  input logic                 clk,
  input logic                 reset,
  mat_transform_2pass_if.slave bus
);
  localparam int LN    = $clog2(N);
  localparam int MW    = (DATA_W > TMP_W) ? DATA_W : TMP_W;
  localparam int PW    = MW + COEF_W;
  localparam int ACC_W = PW + LN;
  localparam int RW    = ACC_W + 1;

  localparam logic signed [RW-1:0] RND1 =
    ({{(RW-1){1'b0}}, 1'b1} << SHIFT1) >> 1;
  localparam logic signed [RW-1:0] RND2 =
    ({{(RW-1){1'b0}}, 1'b1} << SHIFT2) >> 1;
  localparam logic signed [RW-1:0] TMAX =
    {{(RW-TMP_W+1){1'b0}}, {(TMP_W-1){1'b1}}};
  localparam logic signed [RW-1:0] TMIN =
    {{(RW-TMP_W+1){1'b1}}, {(TMP_W-1){1'b0}}};
  localparam logic signed [RW-1:0] OMAX =
    {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN =
    {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P1_DRAIN,
    S_P2,
    S_P2_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [LN-1:0] r_i;
  logic [LN-1:0] r_j;
  logic          r_dc;
  logic          w_last;
  logic          w_issue;
  logic          w_enter;
  logic          w_abt;
  logic          w_start;

  logic signed [TMP_W-1:0] r_t    [N][N];
  logic signed [TMP_W-1:0] r_trow [N];

  logic          r_v1;
  logic          r_p2_1;
  logic [LN-1:0] r_i1;
  logic [LN-1:0] r_j1;
  logic          r_v2;
  logic          r_p2_2;
  logic [LN-1:0] r_i2;
  logic [LN-1:0] r_j2;
  logic          r_sat;

  logic signed [MW-1:0]     w_op   [N];
  logic signed [COEF_W-1:0] w_cf   [N];
  logic signed [PW-1:0]     w_prod [N];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  r_sum;

  logic signed [RW-1:0] w_ext;
  logic signed [RW-1:0] w_rs;
  logic signed [RW-1:0] w_max;
  logic signed [RW-1:0] w_min;
  logic signed [RW-1:0] w_cl;
  logic                 w_hi;
  logic                 w_lo;

  assign w_last  = (r_i == LN'(N-1))
                && (r_j == LN'(N-1));
  assign w_issue = (r_state == S_P1)
                || (r_state == S_P2);
  assign w_abt   = bus.abort && (r_state != S_IDLE);
  assign w_start = bus.start && (r_state == S_IDLE);
  assign w_enter = (w_next != r_state)
                && ((w_next == S_P1) || (w_next == S_P2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (bus.start) w_next = S_P1;
      S_P1:       if (w_last)    w_next = S_P1_DRAIN;
      S_P1_DRAIN: if (r_dc)      w_next = S_P2;
      S_P2:       if (w_last)    w_next = S_P2_DRAIN;
      S_P2_DRAIN: if (r_dc)      w_next = S_DONE;
      S_DONE:                    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
    if (w_abt) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i  <= '0;
      r_j  <= '0;
      r_dc <= 1'b0;
    end else begin
      if (w_enter) begin
        r_i <= '0;
        r_j <= '0;
      end else if (w_issue) begin
        r_j <= r_j + 1'b1;
        if (r_j == LN'(N-1)) r_i <= r_i + 1'b1;
      end
      r_dc <= ((r_state == S_P1_DRAIN)
            || (r_state == S_P2_DRAIN)) && !r_dc;
    end
  end

  // pass 2 multiplies the registered T row in place of the X row
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_cf[k] = $signed(bus.coef_col_data[k*COEF_W +: COEF_W]);
      w_op[k] = r_p2_1 ? MW'(r_trow[k])
              : MW'($signed(bus.x_row_data[k*DATA_W +: DATA_W]));
      w_prod[k] = PW'(w_op[k]) * PW'(w_cf[k]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++)
      w_sum = w_sum + ACC_W'(w_prod[k]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_p2_1 <= 1'b0;
      r_i1   <= '0;
      r_j1   <= '0;
      r_v2   <= 1'b0;
      r_p2_2 <= 1'b0;
      r_i2   <= '0;
      r_j2   <= '0;
      r_sum  <= '0;
    end else begin
      r_v1   <= w_issue && !w_abt;
      r_p2_1 <= (r_state == S_P2);
      r_i1   <= r_i;
      r_j1   <= r_j;
      r_v2   <= r_v1 && !w_abt;
      r_p2_2 <= r_p2_1;
      r_i2   <= r_i1;
      r_j2   <= r_j1;
      r_sum  <= w_sum;
    end
  end

  always_comb begin
    w_ext = RW'(r_sum);
    if (r_p2_2) begin
      w_rs  = (w_ext + RND2) >>> SHIFT2;
      w_max = OMAX;
      w_min = OMIN;
    end else begin
      w_rs  = (w_ext + RND1) >>> SHIFT1;
      w_max = TMAX;
      w_min = TMIN;
    end
    w_hi = w_rs > w_max;
    w_lo = w_rs < w_min;
    w_cl = w_hi ? w_max : (w_lo ? w_min : w_rs);
  end

  always_ff @(posedge clk) begin
    if (r_state == S_P2)
      for (int k = 0; k < N; k++)
        r_trow[k] <= r_t[r_i][k];
    if (r_v2 && !r_p2_2)
      r_t[r_i2][r_j2] <= w_cl[TMP_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_sat <= 1'b0;
    else if (w_start)              r_sat <= 1'b0;
    else if (r_v2 && (w_hi || w_lo)) r_sat <= 1'b1;
  end

  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = (r_state == S_DONE);
  assign bus.sat_flag      = r_sat;
  assign bus.x_row_addr    = r_i;
  assign bus.coef_col_addr = r_j;
  assign bus.coef_bank     = (r_state == S_P2);
  assign bus.y_wr_en       = r_v2 && r_p2_2;
  assign bus.y_wr_i        = r_i2;
  assign bus.y_wr_j        = r_j2;
  assign bus.y_wr_data     = bus.y_wr_en ? w_cl[OUT_W-1:0] : '0;
endmodule

// File: tb/tb_mat_transform_2pass.sv
// Bench for mat_transform_2pass: N=8 default and N=4/SHIFT1=1 instances
// checked against an arithmetic matrix-product reference model.
module tb_mat_transform_2pass;
  logic clk = 1'b0;
  logic rst;
  logic st;
  logic ab;
  int   sel;

  always #5 clk = ~clk;

  mat_transform_2pass_if #(.N(8)) ifa();
  mat_transform_2pass_if #(.N(4)) ifb();

  mat_transform_2pass #(.N(8)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa)
  );
  mat_transform_2pass #(.N(4), .SHIFT1(1)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb)
  );

  assign ifa.start = st && (sel == 0);
  assign ifb.start = st && (sel == 1);
  assign ifa.abort = ab && (sel == 0);
  assign ifb.abort = ab && (sel == 1);

  int xm  [16][16];
  int c0m [16][16];
  int c1m [16][16];
  int tm  [16][16];
  int ym  [16][16];
  bit exp_sat;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int e0, nn, wr_cnt, done_cnt, done_at;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural memories: 1-cycle read latency
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      ifa.x_row_data[k*8 +: 8] <= 8'(xm[ifa.x_row_addr][k]);
      ifa.coef_col_data[k*8 +: 8] <= 8'(ifa.coef_bank
        ? c1m[k][ifa.coef_col_addr] : c0m[k][ifa.coef_col_addr]);
    end
    for (int k = 0; k < 4; k++) begin
      ifb.x_row_data[k*8 +: 8] <= 8'(xm[ifb.x_row_addr][k]);
      ifb.coef_col_data[k*8 +: 8] <= 8'(ifb.coef_bank
        ? c1m[k][ifb.coef_col_addr] : c0m[k][ifb.coef_col_addr]);
    end
  end

  logic m_busy, m_done, m_sat, m_wen;
  int   m_wi, m_wj, m_wd;
  assign m_busy = sel ? ifb.busy     : ifa.busy;
  assign m_done = sel ? ifb.done     : ifa.done;
  assign m_sat  = sel ? ifb.sat_flag : ifa.sat_flag;
  assign m_wen  = sel ? ifb.y_wr_en  : ifa.y_wr_en;
  assign m_wi   = sel ? int'(ifb.y_wr_i) : int'(ifa.y_wr_i);
  assign m_wj   = sel ? int'(ifb.y_wr_j) : int'(ifa.y_wr_j);
  assign m_wd   = sel ? int'($signed(ifb.y_wr_data))
                      : int'($signed(ifa.y_wr_data));

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m_wen) begin
        chk("wr_i", m_wi, wr_cnt / nn);
        chk("wr_j", m_wj, wr_cnt % nn);
        chk("y", m_wd, ym[(wr_cnt / nn) % 16][wr_cnt % nn]);
        wr_cnt++;
      end
      if (m_done) begin
        done_cnt++;
        done_at = cyc - e0 + 1;
      end
    end
  end

  function automatic longint rnd_sh(longint v, int s);
    if (s == 0) return v;
    return (v + (longint'(1) << (s - 1))) >>> s;
  endfunction

  function automatic longint clampw(longint v, int w, output bit f);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -hi - 1;
    f = 1'b0;
    if (v > hi) begin f = 1'b1; return hi; end
    if (v < lo) begin f = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model(input int n, input int s1, input int s2);
    longint acc;
    bit f;
    exp_sat = 1'b0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++)
          acc += longint'(xm[i][k]) * c0m[k][j];
        tm[i][j] = int'(clampw(rnd_sh(acc, s1), 16, f));
        exp_sat |= f;
      end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++)
          acc += longint'(tm[i][k]) * c1m[k][j];
        ym[i][j] = int'(clampw(rnd_sh(acc, s2), 16, f));
        exp_sat |= f;
      end
  endtask

  task automatic fill_ident(input int sc);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        c0m[i][j] = (i == j) ? sc : 0;
        c1m[i][j] = (i == j) ? 1 : 0;
        xm[i][j]  = i * 8 + j - 32;
      end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        xm[i][j]  = v;
        c0m[i][j] = v;
        c1m[i][j] = v;
      end
  endtask

  task automatic fill_rand(input int xr, input int cr);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        xm[i][j]  = int'($urandom_range(0, 2 * xr)) - xr;
        c0m[i][j] = int'($urandom_range(0, 2 * cr)) - cr;
        c1m[i][j] = int'($urandom_range(0, 2 * cr)) - cr;
      end
  endtask

  task automatic wait_cyc(input int c);
    for (int t = 0; t < 1000 && (cyc - e0 + 1 < c); t++)
      @(negedge clk);
  endtask

  task automatic kick();
    wr_cnt   = 0;
    done_cnt = 0;
    done_at  = 0;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    st = 1'b0;
  endtask

  // mode 0: plain, 1: stray start in P1, 2: abort in P2
  task automatic run(input int s, input int mode, input int s1);
    sel = s;
    nn  = s ? 4 : 8;
    model(nn, s1, 0);
    kick();
    @(negedge clk);
    chk("sat_clr", m_sat, 0);
    chk("busy_on", m_busy, 1);
    if (mode == 1) begin
      wait_cyc(50);
      st = 1'b1;
      @(posedge clk);
      #1 st = 1'b0;
    end
    if (mode == 2) begin
      wait_cyc(100);
      ab = 1'b1;
      @(posedge clk);
      #1 ab = 1'b0;
      @(negedge clk);
      chk("abort_busy", m_busy, 0);
      chk("abort_wen", m_wen, 0);
      chk("abort_wr", wr_cnt, 32);
      repeat (20) @(negedge clk);
      chk("abort_done", done_cnt, 0);
      chk("abort_wr2", wr_cnt, 32);
      return;
    end
    for (int t = 0; t < 800 && done_cnt == 0; t++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_cnt", done_cnt, 1);
    chk("done_cyc", done_at, 2 * nn * nn + 5);
    chk("writes", wr_cnt, nn * nn);
    chk("sat", m_sat, exp_sat);
    chk("busy_off", m_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    st  = 1'b0;
    ab  = 1'b0;
    sel = 0;
    nn  = 8;
    fill_ident(1);
    repeat (3) @(negedge clk);
    chk("rst_a", {ifa.busy, ifa.done, ifa.sat_flag, ifa.y_wr_en,
      ifa.coef_bank, ifa.x_row_addr, ifa.coef_col_addr,
      ifa.y_wr_i, ifa.y_wr_j, ifa.y_wr_data}, 0);
    chk("rst_b", {ifb.busy, ifb.done, ifb.sat_flag, ifb.y_wr_en,
      ifb.coef_bank, ifb.x_row_addr, ifb.coef_col_addr,
      ifb.y_wr_i, ifb.y_wr_j, ifb.y_wr_data}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill_ident(1);
    run(0, 0, 0);
    fill_const(127);
    run(0, 0, 0);
    fill_ident(1);
    run(0, 0, 0);
    fill_rand(128, 8);
    run(0, 1, 0);
    fill_rand(100, 20);
    run(0, 2, 0);
    fill_rand(127, 127);
    run(0, 0, 0);
    fill_rand(60, 6);
    run(0, 0, 0);

    // asynchronous reset in the middle of pass 1
    sel = 0;
    nn  = 8;
    kick();
    wait_cyc(20);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid", {ifa.busy, ifa.done, ifa.sat_flag, ifa.y_wr_en,
      ifa.coef_bank, ifa.x_row_addr, ifa.coef_col_addr,
      ifa.y_wr_i, ifa.y_wr_j, ifa.y_wr_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    wr_cnt   = 0;
    done_cnt = 0;
    repeat (150) @(negedge clk);
    chk("rst_nowr", wr_cnt, 0);
    chk("rst_nodone", done_cnt, 0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        xm[i][j]  = 0;
        c0m[i][j] = (i == j) ? 3 : 0;
        c1m[i][j] = (i == j) ? 1 : 0;
      end
    xm[0][0] = 1;
    xm[0][1] = -1;
    run(1, 0, 1);
    fill_rand(128, 128);
    run(1, 0, 1);
    fill_rand(50, 9);
    run(1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
